npu_mac_engine: RTL and testbench



---
 rtl/npu_mac_engine.sv | 146 ++++++++++++++
 tb/tb_npu_mac_engine.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/npu_mac_engine.sv
// npu_mac_engine: host-mapped K_H x K_W conv pipeline with byte packer plus NUM_PE FC MAC lanes.
// Define NPU_SATURATE_EN to saturate the requantised byte instead of truncating it.
module npu_mac_engine #(
  parameter int K_H    = 3,
  parameter int K_W    = 3,
  parameter int NUM_PE = 4,
  parameter int ACC_W  = 24,
  parameter int ADDR_W = 16
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [31:0]       dina,
  output logic [31:0]       douta,
  output logic              done_o
);
  localparam int NK = K_H * K_W;
  typedef enum logic [1:0] {IDLE, MUL, SUM, POST} state_t;
  state_t state, state_n;
  logic [7:0] img [K_H][K_W];
  logic signed [7:0] wgt [K_H][K_W];
  logic signed [16:0] prod [NK];
  logic signed [15:0] fcp [NUM_PE];
  logic signed [ACC_W-1:0] acc [NUM_PE];
  logic signed [ACC_W-1:0] sum, sum_n, raw, y, q;
  logic signed [7:0] act;
  logic [31:0] pack, pack_n, word_base, rdata;
  logic [2:0] pack_cnt, cnt_n, cnt_base, sel;
  logic [3:0] idx;
  logic [7:0] qb;
  logic [4:0] shift;
  logic relu_en, done, err, busy, wr, rd, ctl, start, acc_clr, win_clr, pack_clr;
  logic push_img, push_w, fc, collide, err_clr, post, unused_bits;
  assign sel = addra[14:12];
  assign idx = addra[3:0];
  assign wr = ena & wea;
  assign rd = ena & ~wea;
  assign ctl = wr && sel == 3'd5;
  assign start = ctl & dina[0];
  assign acc_clr = ctl & dina[1];
  assign win_clr = ctl & dina[2];
  assign pack_clr = ctl & dina[3];
  assign push_img = wr && sel == 3'd1;
  assign push_w = wr && sel == 3'd2;
  assign fc = wr && sel == 3'd3;
  assign busy = state != IDLE;
  assign post = state == POST;
  assign collide = busy && (start || push_img || push_w || win_clr);
  assign err_clr = ctl && !dina[0] && !dina[1];
  assign unused_bits = ^{addra, dina, q};
  always_comb begin
    state_n = state == IDLE ? (start ? MUL : IDLE) : state == MUL ? SUM : state == SUM ? POST : IDLE;
    sum_n = '0;
    for (int i = 0; i < NK; i++) sum_n = sum_n + ACC_W'(prod[i]);
    for (int i = 0; i < NUM_PE; i++) fcp[i] = $signed(dina[8*i +: 8]) * act;
  end
  // Requantise: optional ReLU, arithmetic shift, then reduce to one byte.
  always_comb begin
    y = (relu_en && sum[ACC_W-1]) ? '0 : sum;
    q = y >>> shift;
`ifdef NPU_SATURATE_EN
    qb = q > ACC_W'(127) ? 8'h7f : q < -ACC_W'(128) ? 8'h80 : q[7:0];
`else
    qb = q[7:0];
`endif
    cnt_base = pack_clr ? 3'd0 : pack_cnt;
    word_base = pack_clr ? 32'd0 : pack;
    pack_n = !post ? word_base : cnt_base == 3'd4 ? {24'd0, qb} : word_base | ({24'd0, qb} << {cnt_base[1:0], 3'b000});
    cnt_n = !post ? cnt_base : cnt_base == 3'd4 ? 3'd1 : cnt_base + 3'd1;
  end
  always_comb begin
    rdata = '0;
    if (sel == 3'd6) rdata = {busy, err, 26'd0, pack_cnt, done};
    else if (sel == 3'd7) begin
      if (idx == 4'd0) rdata = 32'(raw);
      else if (idx == 4'd1) rdata = pack;
      for (int i = 0; i < NUM_PE; i++) if (idx == 4'(i + 2)) rdata = 32'(acc[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      douta <= '0;
      done_o <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      relu_en <= 1'b0;
      shift <= '0;
      act <= '0;
      sum <= '0;
      raw <= '0;
      pack <= '0;
      pack_cnt <= '0;
      for (int r = 0; r < K_H; r++)
        for (int c = 0; c < K_W; c++) begin
          img[r][c] <= '0;
          wgt[r][c] <= '0;
        end
      for (int i = 0; i < NK; i++) prod[i] <= '0;
      for (int i = 0; i < NUM_PE; i++) acc[i] <= '0;
    end else begin
      state <= state_n;
      if (rd) douta <= rdata;
      if (post) done_o <= 1'b1;
      if (post) done <= 1'b1;
      else if (rd && sel == 3'd6) done <= 1'b0;
      if (collide) err <= 1'b1;
      else if (err_clr) err <= 1'b0;
      if (ctl) begin
        relu_en <= dina[8];
        shift <= dina[20:16];
      end
      if (wr && sel == 3'd4) act <= dina[7:0];
      // Columns enter on the right and shift toward column 0.
      for (int r = 0; r < K_H; r++) begin
        if (win_clr && !busy) begin
          for (int c = 0; c < K_W; c++) begin
            img[r][c] <= '0;
            wgt[r][c] <= '0;
          end
        end
        if (push_img && !busy) begin
          for (int c = 0; c < K_W - 1; c++) img[r][c] <= img[r][c+1];
          img[r][K_W-1] <= dina[8*r +: 8];
        end
        if (push_w && !busy) begin
          for (int c = 0; c < K_W - 1; c++) wgt[r][c] <= wgt[r][c+1];
          wgt[r][K_W-1] <= dina[8*r +: 8];
        end
      end
      if (state == MUL)
        for (int r = 0; r < K_H; r++)
          for (int c = 0; c < K_W; c++)
            prod[r*K_W+c] <= $signed({9'd0, img[r][c]}) * $signed({{9{wgt[r][c][7]}}, wgt[r][c]});
      if (state == SUM) sum <= sum_n;
      if (post) raw <= sum;
      pack <= pack_n;
      pack_cnt <= cnt_n;
      for (int i = 0; i < NUM_PE; i++)
        if (fc) acc[i] <= (acc_clr ? ACC_W'(0) : acc[i]) + ACC_W'(fcp[i]);
        else if (acc_clr) acc[i] <= '0;
    end
  end
endmodule

// File: tb/tb_npu_mac_engine.sv
// tb_npu_mac_engine: directed vector table for the conv path plus hand sequences for packer, FC, collisions and reset.
module tb_npu_mac_engine;
  logic clk = 1'b0, rst = 1'b1, ena = 1'b0, wea = 1'b0, done_o;
  logic [15:0] addra = '0;
  logic [31:0] dina = '0, douta, d;
  int errors = 0, checks = 0;

  npu_mac_engine dut (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra),
    .dina(dina), .douta(douta), .done_o(done_o)
  );

  always #5 clk = ~clk;

`ifdef NPU_SATURATE_EN
  localparam logic [7:0] B_BIG = 8'h7f, B_NEG = 8'h80;
`else
  localparam logic [7:0] B_BIG = 8'h89, B_NEG = 8'h48;
`endif

  typedef struct {
    logic [23:0] img;
    logic [23:0] w;
    logic        relu;
    logic [4:0]  sh;
    int          raw;
    logic [7:0]  b;
  } vec_t;
  vec_t v [8];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic logic [31:0] ctl(input logic r, input logic [4:0] s, input logic [3:0] b);
    return {11'd0, s, 7'd0, r, 4'd0, b};
  endfunction

  task automatic wr(input logic [2:0] s, input logic [3:0] i, input logic [31:0] x);
    ena = 1'b1; wea = 1'b1; addra = {1'b0, s, 8'd0, i}; dina = x;
    @(negedge clk);
    ena = 1'b0; wea = 1'b0;
  endtask

  task automatic rd(input logic [2:0] s, input logic [3:0] i, output logic [31:0] x);
    ena = 1'b1; wea = 1'b0; addra = {1'b0, s, 8'd0, i};
    @(negedge clk);
    ena = 1'b0;
    x = douta;
  endtask

  task automatic load(input logic [23:0] im0, input logic [23:0] im1, input logic [23:0] im2, input logic [23:0] w);
    wr(3'd1, 4'd0, {8'd0, im0});
    wr(3'd1, 4'd0, {8'd0, im1});
    wr(3'd1, 4'd0, {8'd0, im2});
    repeat (3) wr(3'd2, 4'd0, {8'd0, w});
  endtask

  task automatic conv_n(input logic [7:0] n);
    load(24'd0, 24'd0, {16'd0, n}, 24'h000001);
    wr(3'd5, 4'd0, ctl(1'b0, 5'd0, 4'b0001));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    v[0] = '{24'h010101, 24'h010101, 1'b0, 5'd0, 9, 8'h09};
    v[1] = '{24'h020202, 24'hffffff, 1'b1, 5'd0, -18, 8'h00};
    v[2] = '{24'h020202, 24'hffffff, 1'b0, 5'd0, -18, 8'hee};
    v[3] = '{24'hffffff, 24'h7f7f7f, 1'b0, 5'd0, 291465, B_BIG};
    v[4] = '{24'hffffff, 24'h7f7f7f, 1'b0, 5'd12, 291465, 8'h47};
    v[5] = '{24'hffffff, 24'h808080, 1'b0, 5'd4, -293760, B_NEG};
    v[6] = '{24'h030303, 24'h020202, 1'b1, 5'd1, 54, 8'h1b};
    v[7] = '{24'hffffff, 24'h7f7f7f, 1'b1, 5'd0, 291465, B_BIG};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_douta", douta, 32'd0);
    chk("reset_done_o", {31'd0, done_o}, 32'd0);
    rd(3'd6, 4'd0, d); chk("reset_status", d, 32'd0);
    rd(3'd7, 4'd1, d); chk("reset_packed", d, 32'd0);
    rd(3'd7, 4'd2, d); chk("reset_acc0", d, 32'd0);

    // Latency: raw still old when requested 3 cycles after START, new at 4.
    load(24'h010101, 24'h010101, 24'h010101, 24'h010101);
    wr(3'd5, 4'd0, ctl(1'b0, 5'd0, 4'b0001));
    repeat (2) @(negedge clk);
    rd(3'd7, 4'd0, d); chk("latency_early_raw", d, 32'd0);
    rd(3'd7, 4'd0, d); chk("latency_raw", d, 32'd9);
    chk("latency_done_o", {31'd0, done_o}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      wr(3'd5, 4'd0, ctl(v[i].relu, v[i].sh, 4'b1000));
      load(v[i].img, v[i].img, v[i].img, v[i].w);
      wr(3'd5, 4'd0, ctl(v[i].relu, v[i].sh, 4'b0001));
      repeat (3) @(negedge clk);
      rd(3'd7, 4'd0, d); chk($sformatf("vec%0d_raw", i), d, 32'(v[i].raw));
      rd(3'd7, 4'd1, d); chk($sformatf("vec%0d_byte", i), d, {24'd0, v[i].b});
      rd(3'd6, 4'd0, d); chk($sformatf("vec%0d_status", i), d, 32'h3);
    end

    // Packer fill, wrap, and clear coinciding with a POST push.
    wr(3'd5, 4'd0, ctl(1'b0, 5'd0, 4'b1000));
    for (int n = 1; n <= 4; n++) conv_n(8'(n));
    rd(3'd7, 4'd1, d); chk("pack4_word", d, 32'h04030201);
    rd(3'd6, 4'd0, d); chk("pack4_status", d, 32'h9);
    conv_n(8'd5);
    rd(3'd7, 4'd1, d); chk("pack5_word", d, 32'h00000005);
    rd(3'd6, 4'd0, d); chk("pack5_status", d, 32'h3);
    load(24'd0, 24'd0, 24'd6, 24'h000001);
    wr(3'd5, 4'd0, ctl(1'b0, 5'd0, 4'b0001));
    repeat (2) @(negedge clk);
    wr(3'd5, 4'd0, ctl(1'b0, 5'd0, 4'b1000));
    rd(3'd7, 4'd1, d); chk("packclr_post_word", d, 32'h00000006);
    rd(3'd6, 4'd0, d); chk("packclr_post_status", d, 32'h3);

    // FC lanes.
    wr(3'd4, 4'd0, 32'd3);
    wr(3'd3, 4'd0, 32'h0500ff02);
    wr(3'd3, 4'd0, 32'h0500ff02);
    rd(3'd7, 4'd2, d); chk("fc_acc0", d, 32'd12);
    rd(3'd7, 4'd3, d); chk("fc_acc1", d, -32'sd6);
    rd(3'd7, 4'd4, d); chk("fc_acc2", d, 32'd0);
    rd(3'd7, 4'd5, d); chk("fc_acc3", d, 32'd30);
    wr(3'd5, 4'd0, ctl(1'b0, 5'd0, 4'b0010));
    for (int i = 0; i < 4; i++) begin
      rd(3'd7, 4'(i + 2), d); chk($sformatf("fc_clr_acc%0d", i), d, 32'd0);
    end
    wr(3'd4, 4'd0, 32'h000000fe);
    wr(3'd3, 4'd0, 32'h017f8001);
    rd(3'd7, 4'd2, d); chk("fc_neg_acc0", d, -32'sd2);
    rd(3'd7, 4'd3, d); chk("fc_neg_acc1", d, 32'd256);
    rd(3'd7, 4'd4, d); chk("fc_neg_acc2", d, -32'sd254);
    rd(3'd7, 4'd5, d); chk("fc_neg_acc3", d, -32'sd2);
    rd(3'd7, 4'd9, d); chk("unmapped_idx", d, 32'd0);
    rd(3'd0, 4'd0, d); chk("unmapped_sel", d, 32'd0);

    // Busy collisions: second START and an image push are dropped.
    wr(3'd5, 4'd0, ctl(1'b0, 5'd0, 4'b1100));
    load(24'h010101, 24'h010101, 24'h010101, 24'h010101);
    wr(3'd5, 4'd0, ctl(1'b0, 5'd0, 4'b0001));
    wr(3'd5, 4'd0, ctl(1'b0, 5'd0, 4'b0001));
    wr(3'd1, 4'd0, 32'h00050505);
    repeat (2) @(negedge clk);
    rd(3'd6, 4'd0, d); chk("collide_status", d, 32'h40000003);
    rd(3'd7, 4'd0, d); chk("collide_raw", d, 32'd9);
    wr(3'd5, 4'd0, 32'd0);
    rd(3'd6, 4'd0, d); chk("err_clear_status", d, 32'h2);
    wr(3'd5, 4'd0, ctl(1'b0, 5'd0, 4'b0001));
    rd(3'd6, 4'd0, d); chk("busy_status", d, 32'h80000002);
    repeat (2) @(negedge clk);
    rd(3'd7, 4'd0, d); chk("window_kept_raw", d, 32'd9);
    rd(3'd6, 4'd0, d); chk("second_status", d, 32'h5);

    // Reset while the pipeline is in SUM.
    wr(3'd5, 4'd0, ctl(1'b0, 5'd0, 4'b0001));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rd(3'd6, 4'd0, d); chk("midrst_status", d, 32'd0);
    rd(3'd7, 4'd0, d); chk("midrst_raw", d, 32'd0);
    rd(3'd7, 4'd1, d); chk("midrst_packed", d, 32'd0);
    rd(3'd7, 4'd2, d); chk("midrst_acc0", d, 32'd0);
    chk("midrst_done_o", {31'd0, done_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
